// File: rtl/sram_data_mem_ctrl.sv
// MEM-stage data-memory responder: serves 32-bit loads/stores from a 16-bit async SRAM
// as two half-word phases of WAIT_CYCLES each. Optional read buffer: define SRAM_READ_BUFFER_EN.
module sram_data_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] read_data_reg;

    logic [16:0] word_idx;
    logic        req;
    logic        is_write;
    logic        phase_last;
    logic        in_access;
    logic        buf_hit;
    logic [31:0] buf_rd_data;

    assign word_idx   = 17'((address - BASE_ADDR) >> 2);
    assign req        = rd_en | wr_en;
    assign is_write   = wr_en;
    assign phase_last = (cnt_reg == LAST_CNT);
    assign in_access  = (state_reg == LO) || (state_reg == HI);

`ifdef SRAM_READ_BUFFER_EN
    logic        buf_valid_reg;
    logic [16:0] buf_tag_reg;
    logic [31:0] buf_data_reg;

    assign buf_hit     = rd_en && !wr_en && buf_valid_reg && (buf_tag_reg == word_idx);
    assign buf_rd_data = buf_data_reg;

    // Any write invalidates the buffer as it leaves IDLE, so the buffer never holds stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_reg <= 1'b0;
        end else if (state_reg == IDLE && wr_en) begin
            buf_valid_reg <= 1'b0;
        end else if (state_reg == HI && phase_last && !is_write) begin
            buf_valid_reg <= 1'b1;
            buf_tag_reg   <= word_idx;
            buf_data_reg  <= {sram_dq_in, read_data_reg[15:0]};
        end
    end
`else
    assign buf_hit     = 1'b0;
    assign buf_rd_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (buf_hit) begin
                    state_next = DONE;
                end else if (req) begin
                    state_next = LO;
                    cnt_next   = '0;
                end
            end
            LO: begin
                if (phase_last) begin
                    state_next = HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            HI: begin
                if (phase_last) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pin outputs are decoded from registered state and the request inputs the MEM stage holds.
    always_comb begin
        ready       = ((state_reg == IDLE) && !req) || (state_reg == DONE);
        sram_addr   = '0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        if (in_access) begin
            sram_addr = {word_idx, (state_reg == HI)};
            if (is_write) begin
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state_reg == HI) ? write_data[31:16] : write_data[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_reg <= '0;
        end else if (state_reg == IDLE && buf_hit) begin
            read_data_reg <= buf_rd_data;
        end else if (!is_write && phase_last) begin
            if (state_reg == LO) begin
                read_data_reg[15:0] <= sram_dq_in;
            end else if (state_reg == HI) begin
                read_data_reg[31:16] <= sram_dq_in;
            end
        end
    end

    assign read_data = read_data_reg;

endmodule

// File: tb/tb_sram_data_mem_ctrl.sv
// Scoreboard bench for sram_data_mem_ctrl: word-level reference model plus a behavioural SRAM.
module tb_sram_data_mem_ctrl;

    localparam int          W    = 2;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int          FULL_LAT = 1 + 2 * W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    always #5 clk = ~clk;

    sram_data_mem_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_we_n(sram_we_n),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
    );

    // Behavioural asynchronous SRAM
    logic [15:0] sram_mem [0:4095];
    assign sram_dq_in = sram_dq_oe ? 16'h0000 : sram_mem[sram_addr[11:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr[11:0]] <= sram_dq_out;
    end

    typedef struct {
        logic        is_write;
        logic [16:0] w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_txn    = 0;
    bit  mon_en   = 1'b0;

    // Reference model state (word-granular memory, last load result, read buffer)
    logic [31:0] ref_mem [0:1023];
    logic [31:0] last_rd = '0;
    bit          rbuf_valid = 1'b0;
    logic [16:0] rbuf_w = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Issue one access, push its expectation, hold inputs until DONE has been seen.
    task automatic txn(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        sb_t e;
        bit  hit;
        int  n;
        e.is_write = wr;
        e.w        = 17'((a - BASE) >> 2);
        e.addr     = a;
        e.wdata    = d;
        if (wr) begin
            ref_mem[e.w[9:0]] = d;
            e.lat      = FULL_LAT;
            e.rdata    = last_rd;
            rbuf_valid = 1'b0;
        end else begin
`ifdef SRAM_READ_BUFFER_EN
            hit = rbuf_valid && (rbuf_w == e.w);
`else
            hit = 1'b0;
`endif
            e.lat      = hit ? 1 : FULL_LAT;
            e.rdata    = ref_mem[e.w[9:0]];
            last_rd    = e.rdata;
            rbuf_valid = 1'b1;
            rbuf_w     = e.w;
        end
        sb_q.push_back(e);
        wr_en      = wr;
        rd_en      = rd;
        address    = a;
        write_data = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 50);
        if (!ready) begin
            n_fail++;
            $display("FAIL timeout: ready stayed %b for %0d cycles, required 1 within %0d", ready, n, FULL_LAT + 1);
            finish_now();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Monitor: walks each access cycle by cycle and retires it when ready rises with a request held.
    int  mon_k = 0;
    sb_t me;
    always @(negedge clk) begin
        if (mon_en && !(rd_en || wr_en)) begin
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
        end else if (mon_en && sb_q.size() > 0) begin
            int          phase;
            logic [17:0] exp_addr;
            logic [15:0] exp_dq;
            me = sb_q[0];
            phase = 0;
            if (me.lat != 1 && mon_k >= 1 && mon_k <= W) phase = 1;
            else if (me.lat != 1 && mon_k > W && mon_k <= 2 * W) phase = 2;
            exp_addr = (phase == 1) ? {me.w, 1'b0} : (phase == 2) ? {me.w, 1'b1} : 18'd0;
            exp_dq   = !me.is_write ? 16'h0 : (phase == 1) ? me.wdata[15:0] :
                       (phase == 2) ? me.wdata[31:16] : 16'h0;
            chk("ready", 32'(ready), 32'(mon_k == me.lat));
            chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
            chk("sram_we_n", 32'(sram_we_n), 32'(!(me.is_write && phase != 0)));
            chk("sram_dq_oe", 32'(sram_dq_oe), 32'(me.is_write && phase != 0));
            chk("sram_dq_out", 32'(sram_dq_out), 32'(exp_dq));
            if (ready) begin
                chk("latency", 32'(mon_k), 32'(me.lat));
                chk("read_data", read_data, me.rdata);
                $display("txn %0d %s addr=%h wdata=%h read_data=%h cycles=%0d", n_txn,
                         me.is_write ? "WR" : "RD", me.addr, me.wdata, read_data, mon_k);
                n_txn++;
                void'(sb_q.pop_front());
                mon_k = 0;
            end else begin
                mon_k++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) sram_mem[i] = 16'h0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_dq_out", 32'(sram_dq_out), 32'd0);
        mon_en = 1'b1;
        idle(2);

        // Directed: write/read, mapping, priority, back-to-back, read buffer
        txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        idle(1);
        chk("sram_lo_half", 32'(sram_mem[0]), 32'h0000BEEF);
        chk("sram_hi_half", 32'(sram_mem[1]), 32'h0000DEAD);
        txn(1'b0, 1'b1, 32'd1024, 32'h0);
        idle(1);
        txn(1'b0, 1'b1, 32'd1036, 32'h0);
        idle(1);
        txn(1'b1, 1'b1, 32'd1040, 32'h12345678);
        idle(1);
        txn(1'b1, 1'b0, 32'd1028, 32'hCAFEF00D);
        txn(1'b0, 1'b1, 32'd1024, 32'h0);
        txn(1'b0, 1'b1, 32'd1028, 32'h0);
        txn(1'b0, 1'b1, 32'd1024, 32'h0);
        txn(1'b0, 1'b1, 32'd1024, 32'h0);
        txn(1'b1, 1'b0, 32'd2048, 32'hA5A55A5A);
        txn(1'b0, 1'b1, 32'd1024, 32'h0);
        idle(2);

        // Randomized traffic over a small window so reuse and buffer hits occur
        for (int i = 0; i < 200; i++) begin
            bit          wr;
            bit          rd;
            logic [31:0] a;
            wr = ($urandom_range(0, 2) == 0);
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            a  = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            txn(wr, rd, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        // Reset during the HI phase of a write
        mon_en     = 1'b0;
        wr_en      = 1'b1;
        rd_en      = 1'b0;
        address    = 32'd4096;
        write_data = 32'h0BADF00D;
        repeat (1 + W) @(posedge clk);
        #1;
        chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        rst   = 1'b1;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_we_n", 32'(sram_we_n), 32'd1);
        chk("midrst_read_data", read_data, 32'd0);
        chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
        last_rd    = '0;
        rbuf_valid = 1'b0;
        mon_en     = 1'b1;
        idle(1);
        txn(1'b0, 1'b1, 32'd1024, 32'h0);
        idle(2);

        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        finish_now();
    end

endmodule

// File: doc/sram_data_mem_ctrl.md
# sram_data_mem_ctrl

Responder side of the MEM-stage data-memory interface. It accepts 32-bit load/store requests from the MEM stage and serves them from an external 16-bit asynchronous SRAM as two half-word accesses with programmable wait states. It drops `ready` to freeze the pipeline while an access is in flight. It sits between the MEM stage and the off-chip SRAM pins; its `read_data` feeds the MEM-stage pipeline register's memory-result input.

## Interface
- `BASE_ADDR`, default 1024: byte address of data word 0; subtracted from `address` before mapping.
- `WAIT_CYCLES`, default 2, legal range 1–15: cycles per half-word phase.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `rd_en`  in  1  load request from the MEM stage.
- `wr_en`  in  1  store request from the MEM stage; wins over `rd_en` when both are high.
- `address`  in  32  byte address; bits [1:0] ignored.
- `write_data`  in  32  store data.
- `read_data`  out  32  load result; valid while `ready`=1 in DONE.
- `ready`  out  1  0 = freeze pipeline.
- `sram_addr`  out  18  SRAM half-word address.
- `sram_we_n`  out  1  SRAM write strobe, active low.
- `sram_dq_out`  out  16  data driven to the SRAM.
- `sram_dq_oe`  out  1  1 = drive `sram_dq_out` onto the pad.
- `sram_dq_in`  in  16  data returned by the SRAM.

## Operation
- Word index: w = ((address − BASE_ADDR) >> 2) mod 2^17. `sram_addr` = {w, 0} in the LO phase and {w, 1} in the HI phase; 0 in IDLE and DONE.
- FSM states: IDLE, LO, HI, DONE. A 4-bit phase counter counts 0..WAIT_CYCLES−1.
- IDLE:
  - With no request, stay in IDLE.
  - On `rd_en` or `wr_en`, go to LO with the counter at 0.
- LO: after WAIT_CYCLES cycles, go to HI with the counter at 0.
- HI: after WAIT_CYCLES cycles, go to DONE.
- DONE: always go to IDLE after one cycle.
- Writes:
  - In LO/HI, `sram_we_n`=0 and `sram_dq_oe`=1.
  - `sram_dq_out` = `write_data`[15:0] in LO and `write_data`[31:16] in HI.
  - `read_data` is unchanged.
- Reads:
  - `sram_we_n`=1 and `sram_dq_oe`=0 throughout.
  - `sram_dq_in` is sampled on the last cycle of LO into `read_data`[15:0] and on the last cycle of HI into `read_data`[31:16].
- `ready` = 1 in IDLE with no request and in DONE; 0 otherwise.
- The MEM stage holds `address`, `write_data`, `rd_en` and `wr_en` stable while `ready`=0. Changes to them mid-access are undefined.

## Timing
- Reset state: IDLE, counter 0, `read_data`=0, `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
- Reset mid-access: at the next edge the block is in IDLE, `sram_we_n` returns to 1, and the access is abandoned. A partial write may remain in the SRAM.
- Full access: `ready` is low for 1 + 2·WAIT_CYCLES cycles, counted from the cycle the request is first seen, and high for 1 cycle in DONE.
  - With WAIT_CYCLES=2: request seen at cycle 0, `ready`=0 in cycles 0–4, `ready`=1 in cycle 5.
- A request present in the cycle after DONE is a new access.
- Back-to-back requests: one DONE cycle separates accesses, and there is no idle gap beyond it.
- `sram_addr` and `sram_we_n` are decoded from registered state plus held inputs.
- `sram_we_n` is never low in IDLE or DONE.

## Configuration
- Macro: `SRAM_READ_BUFFER_EN`.
- When defined, a one-entry read buffer is compiled in:
  - Contents: valid bit, 17-bit word tag, 32-bit data.
  - Filled on every completed read.
  - A read in IDLE whose w matches a valid tag goes straight to DONE with `read_data` loaded from the buffer, so `ready`=0 for 1 cycle.
  - Any write that enters LO clears the valid bit.
  - Reset clears the valid bit.
- When not defined: no buffer logic, and every read takes the full access.

## Test plan
- Write then read, WAIT_CYCLES=2:
  - Stimulus: `wr_en`, address=1024, data=0xDEADBEEF; then read of address 1024.
  - SRAM model holds 0xBEEF at half-word address 0 and 0xDEAD at half-word address 1.
  - The read returns 0xDEADBEEF.
  - `ready` is low for 5 cycles on each access.
- Address mapping:
  - Stimulus: read address 1036.
  - `sram_addr`=6 during LO and 7 during HI.
- Priority:
  - Stimulus: `rd_en`=`wr_en`=1.
  - A write occurs: `sram_we_n`=0 for 4 cycles and `sram_dq_oe`=1.
- Reset mid-access:
  - Stimulus: assert `rst` during the HI phase of a write.
  - Next cycle: IDLE, `sram_we_n`=1, `ready`=1, `read_data`=0.
- Back-to-back reads at 1024 and 1028:
  - The second access starts the cycle after DONE.
  - `read_data` updates correctly for each read.
- With `SRAM_READ_BUFFER_EN`:
  - Repeat a read of 1024 → `ready` low for 1 cycle and no SRAM activity.
  - A write to 2048, then a read of 1024 → full 5-cycle access.
